// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control FSM (master) and the datapath (slave).
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] aluop;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] resultsrc;
  logic       adrsrc;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       pcwrite;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output aluop, alusrca, alusrcb, resultsrc, adrsrc,
           irwrite, memwrite, regwrite, pcwrite, illegal, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  aluop, alusrca, alusrcb, resultsrc, adrsrc,
           irwrite, memwrite, regwrite, pcwrite, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle RV32I datapath (lw, sw, add/sub, beq).
// Define MC_CTRL_ADDI_EN to add the addi path through EXECI.
module multicycle_control (
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_control_if.master        bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    ALUWB  = 4'd7,
    EXECI  = 4'd8,
    BEQ    = 4'd10
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_aluop, w_alusrca, w_alusrcb, w_resultsrc;
  logic       w_adrsrc, w_irwrite, w_memwrite, w_regwrite;
  logic       w_pcupdate, w_branch, w_illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = FETCH;
    w_aluop     = 2'b00;
    w_alusrca   = 2'b00;
    w_alusrcb   = 2'b00;
    w_resultsrc = 2'b00;
    w_adrsrc    = 1'b0;
    w_irwrite   = 1'b0;
    w_memwrite  = 1'b0;
    w_regwrite  = 1'b0;
    w_pcupdate  = 1'b0;
    w_branch    = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      FETCH: begin
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
        w_irwrite   = bus.mem_ready;
        w_pcupdate  = bus.mem_ready;
        w_next      = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // ALU precomputes the branch target from oldPC + imm
        w_alusrca = 2'b01;
        w_alusrcb = 2'b01;
        case (bus.opcode)
          7'b0000011,
          7'b0100011: w_next = MEMADR;
          7'b0110011: w_next = EXECR;
          7'b1100011: w_next = BEQ;
`ifdef MC_CTRL_ADDI_EN
          7'b0010011: w_next = EXECI;
`endif
          default: begin
            w_next    = FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        w_alusrca = 2'b10;
        w_alusrcb = 2'b01;
        w_next    = bus.opcode[5] ? MEMWR : MEMRD;
      end
      MEMRD: begin
        w_adrsrc = 1'b1;
        w_next   = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        w_resultsrc = 2'b01;
        w_regwrite  = 1'b1;
        w_next      = FETCH;
      end
      MEMWR: begin
        w_adrsrc   = 1'b1;
        w_memwrite = 1'b1;
        w_next     = bus.mem_ready ? FETCH : MEMWR;
      end
      EXECR: begin
        w_alusrca = 2'b10;
        w_aluop   = 2'b10;
        w_next    = ALUWB;
      end
      ALUWB: begin
        w_regwrite = 1'b1;
        w_next     = FETCH;
      end
`ifdef MC_CTRL_ADDI_EN
      EXECI: begin
        w_alusrca = 2'b10;
        w_alusrcb = 2'b01;
        w_next    = ALUWB;
      end
`endif
      BEQ: begin
        w_alusrca = 2'b10;
        w_aluop   = 2'b01;
        w_branch  = 1'b1;
        w_next    = FETCH;
      end
      default: w_next = FETCH;
    endcase
  end

  assign bus.state     = r_state;
  assign bus.aluop     = w_aluop;
  assign bus.alusrca   = w_alusrca;
  assign bus.alusrcb   = w_alusrcb;
  assign bus.resultsrc = w_resultsrc;
  assign bus.adrsrc    = w_adrsrc;
  assign bus.illegal   = w_illegal;
  // Write enables are suppressed while reset is held so an abandoned instruction leaves no trace.
  assign bus.irwrite   = w_irwrite  & rst_n;
  assign bus.memwrite  = w_memwrite & rst_n;
  assign bus.regwrite  = w_regwrite & rst_n;
  assign bus.pcwrite   = (w_pcupdate | (w_branch & bus.zero)) & rst_n;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle RV32I datapath. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the datapath multiplexer selects and write enables, and produces the 2-bit `aluop` consumed directly by `ALUControl`. It supports `lw`, `sw`, R-type `add`/`sub` and `beq`, with `addi` as a compile-time option. Memory accesses stall on a ready handshake.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous reset, active-low (one clock; reset is synchronous and active-low)
- `opcode`  in  7  `instr[6:0]`, taken from the instruction register
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory has completed the current read or write
- `aluop`  out  2  to `ALUControl`: 00 add, 01 sub, 10 decode by funct
- `alusrca`  out  2  00 PC, 01 oldPC, 10 rs1 data
- `alusrcb`  out  2  00 rs2 data, 01 immediate, 10 constant 4
- `resultsrc`  out  2  00 ALUOut, 01 memory data, 10 ALU result
- `adrsrc`  out  1  memory address: 0 PC, 1 result
- `irwrite`, `memwrite`, `regwrite`, `pcwrite`  out  1 each  write enables
- `illegal`  out  1  unrecognised opcode seen in DECODE
- `state`  out  4  current state encoding, for debug

## Operation
- Moore FSM. All outputs decode from the state register, except the enables gated by `mem_ready` and `zero` as noted below. Any output not listed for a state is 0.
- `pcwrite = pcupdate | (branch & zero)`, where `pcupdate` and `branch` are internal.
- **FETCH (0):** `adrsrc`=0, `alusrca`=00, `alusrcb`=10, `aluop`=00, `resultsrc`=10. `irwrite` and `pcupdate` equal `mem_ready`. Stays in FETCH while `mem_ready`=0; goes to DECODE when it is 1.
- **DECODE (1):** `alusrca`=01, `alusrcb`=01, `aluop`=00 (branch target). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 1100011 → BEQ
  - 0010011 → EXECI, only when the macro is defined
  - anything else → FETCH with `illegal`=1 for this cycle
- **MEMADR (2):** `alusrca`=10, `alusrcb`=01, `aluop`=00. Goes to MEMRD if `opcode[5]`=0, otherwise MEMWR.
- **MEMRD (3):** `adrsrc`=1, `resultsrc`=00. Holds until `mem_ready`, then goes to MEMWB.
- **MEMWB (4):** `resultsrc`=01, `regwrite`=1. Next: FETCH.
- **MEMWR (5):** `adrsrc`=1, `resultsrc`=00, `memwrite`=1. `memwrite` stays high until the cycle in which `mem_ready`=1, then the FSM goes to FETCH.
- **EXECR (6):** `alusrca`=10, `alusrcb`=00, `aluop`=10. Next: ALUWB.
- **ALUWB (7):** `resultsrc`=00, `regwrite`=1. Next: FETCH.
- **EXECI (8):** `alusrca`=10, `alusrcb`=01, `aluop`=00. Next: ALUWB.
- **BEQ (10):** `alusrca`=10, `alusrcb`=00, `aluop`=01, `resultsrc`=00, `branch`=1. Next: FETCH.
- Unused encodings (9, 11–15) go to FETCH on the next clock. `illegal` stays 0 in that case.
- `aluop` is never 11, so `ALUControl` never receives an undefined code.

## Timing
- Reset: when `rst_n`=0 at a rising edge, state becomes FETCH. While `rst_n`=0, `irwrite`, `pcwrite`, `regwrite` and `memwrite` are forced to 0. This applies even mid-instruction; a partial instruction is abandoned with no writes.
- Outputs in reset: FETCH decode, i.e. `alusrcb`=10, `resultsrc`=10, all other outputs 0, `state`=0.
- Cycles per instruction with `mem_ready` held at 1:
  - `beq`: 3
  - R-type: 4
  - `addi`: 4
  - `sw`: 4
  - `lw`: 5
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `mem_ready`=1 outside FETCH, MEMRD and MEMWR is ignored.

## Configuration
- `MC_CTRL_ADDI_EN` defined: opcode 0010011 goes DECODE → EXECI → ALUWB → FETCH.
- `MC_CTRL_ADDI_EN` undefined: opcode 0010011 is treated as illegal, and the EXECI state logic is not compiled.

## Test plan
- **`lw`:** `rst_n` low for 2 cycles, then `opcode`=0000011 with `mem_ready`=1 → states 0,1,2,3,4,0. `regwrite`=1 only in state 4; `aluop`=00 throughout.
- **R-type:** `opcode`=0110011 → states 0,1,6,7,0. `aluop`=10 in state 6; `regwrite`=1 in state 7 with `resultsrc`=00.
- **`beq`:** `opcode`=1100011 in two runs.
  - `zero`=1 → `pcwrite`=1 in state 10.
  - `zero`=0 → `pcwrite`=0 in state 10.
  - Both runs: `aluop`=01.
- **`sw` with wait:** `opcode`=0100011 and `mem_ready` low for 3 cycles in MEMWR → `memwrite` high for 4 cycles, then state 0. Total 7 cycles.
- **Illegal opcode:** `opcode`=1111111 → `illegal`=1 in DECODE only, next state 0, no write enables.
- **Reset mid-instruction:** `rst_n`=0 while in MEMWR → `memwrite`=0 that cycle, state 0 next. With `MC_CTRL_ADDI_EN` undefined, `opcode`=0010011 also raises `illegal`.
